// File: rtl/deadband_scan_ctrl_if.sv
// deadband_scan_ctrl_if
//   Request/acknowledge and event-stream bundle for deadband_scan_ctrl.
//   Parameters: W (sample width), NCH (channel count).
//   Signals:
//     req       per-channel sample request (level)
//     sample    packed samples, channel i at [i*W +: W]
//     ack       one-hot grant pulse, sample of that channel consumed
//     evt_valid event available at FIFO head
//     evt_ready consumer accepts the head event
//     evt_chan  channel of head event
//     evt_delta absolute change of head event
//     evt_value new sample value of head event
//   Modports: master = requesters/consumer side, slave = scheduler side.
interface deadband_scan_ctrl_if #(
    parameter int W   = 8,
    parameter int NCH = 4
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]   req;
    logic [NCH*W-1:0] sample;
    logic [NCH-1:0]   ack;
    logic             evt_valid;
    logic             evt_ready;
    logic [CW-1:0]    evt_chan;
    logic [W-1:0]     evt_delta;
    logic [W-1:0]     evt_value;

    modport master (
        output req, sample, evt_ready,
        input  ack, evt_valid, evt_chan, evt_delta, evt_value
    );

    modport slave (
        input  req, sample, evt_ready,
        output ack, evt_valid, evt_chan, evt_delta, evt_value
    );
endinterface

// File: rtl/deadband_scan_ctrl.sv
// deadband_scan_ctrl
//   Shares one deadband change detector among NCH requesters. A winner is
//   picked in IDLE, acknowledged in CAPT, and evaluated in EVAL against the
//   last reported value of its channel. Changes strictly above the
//   programmable threshold are queued in a first-word-fall-through FIFO.
//   Build option: DEADBAND_SCAN_FIXED_PRIO_EN selects fixed priority (lowest
//   index wins, rr pointer held at 0); otherwise round-robin arbitration.
//   Ports:
//     clk        clock, rising edge
//     rst_n      reset, asynchronous, active-high
//     bus        deadband_scan_ctrl_if.slave (req/sample/ack, evt_* stream)
//     thr_we     threshold write strobe
//     thr_wdata  threshold write data
//     ovf        sticky FIFO overflow flag
//     ovf_clr    clears ovf (a simultaneous overflow wins)
module deadband_scan_ctrl #(
    parameter int W     = 8,
    parameter int NCH   = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    deadband_scan_ctrl_if.slave  bus,
    input  logic                 thr_we,
    input  logic [W-1:0]         thr_wdata,
    output logic                 ovf,
    input  logic                 ovf_clr
);
    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CW + 2 * W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAPT = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] chan;
    logic [CW-1:0] rr;
    logic [CW-1:0] win;
    logic          win_found;
    logic [W-1:0]  samp;
    logic [W-1:0]  delta;
    logic [W-1:0]  delta_next;
    logic [W-1:0]  thr;
    logic [W-1:0]  stored [NCH];

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          pend;
    logic [EW-1:0] pend_data;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          qualify;
    logic          accept;
    logic          drop;

    // Arbitration
`ifdef DEADBAND_SCAN_FIXED_PRIO_EN
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (bus.req[i-1]) begin
                win       = CW'(i - 1);
                win_found = 1'b1;
            end
        end
    end
`else
    logic [CW-1:0] idx;

    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = rr + CW'(i);
            if (!win_found && bus.req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        bus.ack = '0;
        if (state == S_CAPT) begin
            bus.ack[chan] = 1'b1;
        end
    end

    always_comb begin
        if (samp >= stored[chan]) begin
            delta_next = samp - stored[chan];
        end else begin
            delta_next = stored[chan] - samp;
        end
    end

    // FIFO status and EVAL decision
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = !empty && bus.evt_ready;
    assign qualify = (state == S_EVAL) && (delta > thr);
    assign accept  = qualify && (!full || pop);
    assign drop    = qualify && full && !pop;

    assign head          = empty ? '0 : mem[rptr[AW-1:0]];
    assign bus.evt_valid = !empty;
    assign bus.evt_chan  = head[EW-1 -: CW];
    assign bus.evt_delta = head[2*W-1 -: W];
    assign bus.evt_value = head[W-1:0];

    // An accepted event is staged for one cycle before it enters the FIFO,
    // so evt_valid rises one edge after the EVAL decision. Room is reserved
    // at EVAL time; only pops can occur before the staged write lands.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= S_IDLE;
            chan      <= '0;
            rr        <= '0;
            samp      <= '0;
            delta     <= '0;
            thr       <= W'(2);
            ovf       <= 1'b0;
            pend      <= 1'b0;
            pend_data <= '0;
            wptr      <= '0;
            rptr      <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                stored[i] <= '0;
            end
        end else begin
            if (thr_we) begin
                thr <= thr_wdata;
            end

            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            pend <= accept;
            if (accept) begin
                pend_data <= {chan, delta, samp};
            end
            wptr <= wptr + (AW+1)'(pend);
            rptr <= rptr + (AW+1)'(pop);

            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        chan  <= win;
                        samp  <= bus.sample[int'(win)*W +: W];
                        state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    delta <= delta_next;
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    if (qualify) begin
                        stored[chan] <= samp;
                    end
`ifdef DEADBAND_SCAN_FIXED_PRIO_EN
                    rr <= '0;
`else
                    rr <= chan + CW'(1);
`endif
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pend) begin
            mem[wptr[AW-1:0]] <= pend_data;
        end
    end
endmodule

// File: tb/tb_deadband_scan_ctrl.sv
// tb_deadband_scan_ctrl
//   Self-checking bench for deadband_scan_ctrl. A behavioural model predicts
//   events into a queue when samples are driven; a monitor pops and compares
//   them when the DUT hands an event over.
module tb_deadband_scan_ctrl;
    localparam int W     = 8;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] delta;
        logic [7:0] value;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       thr_we;
    logic [7:0] thr_wdata;
    logic       ovf;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;

    evt_t       exp_q[$];
    logic [7:0] m_stored [NCH];
    logic [7:0] m_thr;
    logic [1:0] m_rr;
    logic       m_ovf;

    deadband_scan_ctrl_if #(.W(W), .NCH(NCH)) bus ();

    deadband_scan_ctrl #(.W(W), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .thr_we    (thr_we),
        .thr_wdata (thr_wdata),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) m_stored[i] = 8'h00;
        m_thr = 8'h02;
        m_rr  = 2'd0;
        m_ovf = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_sample(input int ch, input logic [7:0] val);
        logic [7:0] d;
        evt_t       e;
        d = (val >= m_stored[ch]) ? val - m_stored[ch] : m_stored[ch] - val;
        if (d > m_thr) begin
            if (exp_q.size() < DEPTH) begin
                e.chan  = 2'(ch);
                e.delta = d;
                e.value = val;
                exp_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
            m_stored[ch] = val;
        end
        m_rr = 2'(ch + 1);
    endfunction

    // Event monitor: sampled 1 time unit after the falling edge.
    always @(negedge clk) begin
        evt_t e;
        #1;
        if (rst_n === 1'b0 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got chan=%0d delta=%h value=%h, required no event",
                         bus.evt_chan, bus.evt_delta, bus.evt_value);
            end else begin
                e = exp_q.pop_front();
                if ({bus.evt_chan, bus.evt_delta, bus.evt_value} !== e) begin
                    errors++;
                    $display("FAIL evt_data: got chan=%0d delta=%h value=%h, required chan=%0d delta=%h value=%h",
                             bus.evt_chan, bus.evt_delta, bus.evt_value, e.chan, e.delta, e.value);
                end
            end
        end
    end

    // One request on one channel; optionally writes the threshold during EVAL.
    task automatic send(input int ch, input logic [7:0] val,
                        input bit thr_in_eval, input logic [7:0] new_thr);
        int cyc;
        @(negedge clk);
        bus.sample[ch*W +: W] = val;
        bus.req[ch] = 1'b1;
        model_sample(ch, val);
        cyc = 0;
        @(negedge clk);
        while (bus.ack[ch] !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.ack !== 4'(1 << ch)) begin
            errors++;
            $display("FAIL send_ack ch%0d: ack=%b, required %b", ch, bus.ack, 4'(1 << ch));
        end
        bus.req[ch] = 1'b0;
        @(negedge clk);
        if (thr_in_eval) begin
            thr_we    = 1'b1;
            thr_wdata = new_thr;
        end
        @(negedge clk);
        thr_we = 1'b0;
        if (thr_in_eval) m_thr = new_thr;
        checks++;
        if (ovf !== m_ovf) begin
            errors++;
            $display("FAIL send_ovf ch%0d val=%h: ovf=%b, required %b", ch, val, ovf, m_ovf);
        end
    endtask

    task automatic drain();
        int cyc;
        bus.evt_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.evt_valid !== 1'b0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: pending expected=%0d evt_valid=%b, required 0 and 0",
                     exp_q.size(), bus.evt_valid);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        bus.req       = '0;
        bus.sample    = '0;
        bus.evt_ready = 1'b0;
        thr_we        = 1'b0;
        thr_wdata     = '0;
        ovf_clr       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0000) begin
            errors++; $display("FAIL reset_ack: ack=%b, required 0000", bus.ack);
        end
        checks++;
        if (bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: evt_valid=%b, required 0", bus.evt_valid);
        end
        checks++;
        if ({bus.evt_chan, bus.evt_delta, bus.evt_value} !== 18'h0) begin
            errors++;
            $display("FAIL reset_evt: chan=%0d delta=%h value=%h, required all 0",
                     bus.evt_chan, bus.evt_delta, bus.evt_value);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_first_event();
        bus.evt_ready = 1'b0;
        @(negedge clk);
        bus.sample[0 +: W] = 8'h05;
        bus.req[0] = 1'b1;
        model_sample(0, 8'h05);
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0001) begin
            errors++; $display("FAIL first_ack: ack=%b, required 0001", bus.ack);
        end
        bus.req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0000 || bus.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_eval: ack=%b evt_valid=%b, required 0000 and 0", bus.ack, bus.evt_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL first_early: evt_valid=%b, required 0", bus.evt_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.evt_valid !== 1'b1) begin
            errors++; $display("FAIL first_valid: evt_valid=%b, required 1", bus.evt_valid);
        end
        checks++;
        if ({bus.evt_chan, bus.evt_delta, bus.evt_value} !== {2'd0, 8'h05, 8'h05}) begin
            errors++;
            $display("FAIL first_head: chan=%0d delta=%h value=%h, required chan=0 delta=05 value=05",
                     bus.evt_chan, bus.evt_delta, bus.evt_value);
        end
        drain();
    endtask

    task automatic test_deadband();
        bus.evt_ready = 1'b1;
        send(0, 8'h07, 1'b0, 8'h00);
        send(0, 8'h08, 1'b0, 8'h00);
        send(1, 8'hF0, 1'b0, 8'h00);
        send(1, 8'h10, 1'b0, 8'h00);
        drain();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int exp_ch;
        bus.evt_ready = 1'b1;
        send(3, 8'h03, 1'b0, 8'h00);
        drain();
        @(negedge clk);
        bus.sample = {8'h73, 8'h62, 8'h51, 8'h40};
        bus.req    = 4'b1111;
        for (int n = 0; n < 5; n++) begin
`ifdef DEADBAND_SCAN_FIXED_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = int'(m_rr);
`endif
            cyc = 0;
            @(negedge clk);
            while (bus.ack === 4'b0000 && cyc < 12) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (bus.ack !== 4'(1 << exp_ch)) begin
                errors++;
                $display("FAIL rr_order grant %0d: ack=%b, required %b", n, bus.ack, 4'(1 << exp_ch));
            end
            model_sample(exp_ch, bus.sample[exp_ch*W +: W]);
        end
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] vals [5];
        vals = '{8'hA0, 8'h20, 8'hA0, 8'h20, 8'hA0};
        bus.evt_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            send(2, vals[n], 1'b0, 8'h00);
        end
        checks++;
        if (exp_q.size() != DEPTH || bus.evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fill: queued=%0d evt_valid=%b, required %0d and 1",
                     exp_q.size(), bus.evt_valid, DEPTH);
        end
        drain();
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: ovf=%b, required 1", ovf);
        end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        m_ovf   = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clr: ovf=%b, required 0", ovf);
        end
        send(2, 8'hA0, 1'b0, 8'h00);
        drain();
    endtask

    task automatic test_threshold();
        logic [7:0] base;
        bus.evt_ready = 1'b1;
        @(negedge clk);
        thr_we    = 1'b1;
        thr_wdata = 8'h10;
        @(negedge clk);
        thr_we = 1'b0;
        m_thr  = 8'h10;
        base = m_stored[3];
        send(3, base + 8'h10, 1'b0, 8'h00);
        send(3, base + 8'h11, 1'b0, 8'h00);
        base = m_stored[3];
        send(3, base + 8'h20, 1'b1, 8'h40);
        base = m_stored[3];
        send(3, base + 8'h30, 1'b0, 8'h00);
        drain();
    endtask

    task automatic test_reset_eval();
        int cyc;
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.sample[0 +: W] = m_stored[0] ^ 8'h80;
        bus.req[0] = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (bus.ack[0] !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        bus.req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ack !== 4'b0000 || bus.evt_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_eval_outputs: ack=%b evt_valid=%b ovf=%b, required 0000 0 0",
                     bus.ack, bus.evt_valid, ovf);
        end
        checks++;
        if ({bus.evt_chan, bus.evt_delta, bus.evt_value} !== 18'h0) begin
            errors++;
            $display("FAIL rst_eval_evt: chan=%0d delta=%h value=%h, required all 0",
                     bus.evt_chan, bus.evt_delta, bus.evt_value);
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL rst_eval_noevt: evt_valid=%b, required 0", bus.evt_valid);
        end
        send(0, 8'h01, 1'b0, 8'h00);
        send(0, 8'h03, 1'b0, 8'h00);
        drain();
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_deadband();
        test_back_to_back();
        test_overflow();
        test_threshold();
        test_reset_eval();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/deadband_scan_ctrl.md
# deadband_scan_ctrl

Scheduler that shares one deadband change-detector among NCH sample requesters. It arbitrates the requesters, keeps the last reported value per channel and compares each new sample against it with a programmable threshold. Samples whose absolute change exceeds the threshold are emitted as events through a small FIFO with a valid/ready handshake. It sits between the input sampling logic and the downstream event consumer, replacing per-channel comparators.

## Interface
Parameters:
- W, 8: sample width, unsigned
- NCH, 4: channel count, power of two ≥ 2
- DEPTH, 4: event FIFO depth, power of two ≥ 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-high (state exactly: reset rst_n, asynchronous, active-high; clock clk)
- req  in  NCH  per-channel sample request, level
- sample  in  NCH*W  packed samples; channel i at [i*W +: W]
- ack  out  NCH  one-hot grant pulse; sample of that channel consumed
- thr_we  in  1  threshold write strobe
- thr_wdata  in  W  threshold write data
- evt_valid  out  1  event available (FIFO not empty)
- evt_ready  in  1  consumer accepts event
- evt_chan  out  log2(NCH)  event channel
- evt_delta  out  W  absolute change
- evt_value  out  W  new sample value
- ovf  out  1  sticky FIFO overflow flag
- ovf_clr  in  1  clears ovf

## Operation
- Reset values: ack=0, evt_valid=0, evt_chan/delta/value=0, ovf=0, FSM=IDLE, FIFO empty, rr pointer=0, every stored value=0, threshold=2.
- FSM states: IDLE, CAPT, EVAL. Every state lasts exactly one cycle except IDLE, which waits for a request.
- IDLE: if req≠0, select the winner. Search starts at the rr pointer and wraps modulo NCH. Register the channel index and its sample, then go to CAPT. If req=0, stay in IDLE.
- CAPT: ack[chan]=1 for this cycle only. Compute delta=|sample−stored[chan]| as unsigned W bits; it cannot overflow. Go to EVAL.
- EVAL: if delta > thr (strictly greater):
  - stored[chan] ← sample.
  - Push {chan, delta, sample} to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, drop the event, set ovf and still update stored[chan].
- EVAL: if delta ≤ thr, nothing is pushed or stored.
- EVAL: in all cases set rr pointer ← chan+1 (mod NCH) and go to IDLE.
- Requester rules:
  - Hold sample stable while req is high and until ack.
  - Drop req in the cycle after ack if it has no new sample.
  - A req still high in the next IDLE counts as a new request.
- FIFO is first-word-fall-through. evt_* show the head entry. A pop occurs when evt_valid && evt_ready.
- Simultaneous push and pop with the FIFO full is accepted with no drop. Push and pop with the FIFO empty is not bypassed; evt_valid rises on the next cycle.
- thr_we: threshold ← thr_wdata at the clock edge. An EVAL in the same cycle uses the old threshold.
- ovf: set in the same cycle as ovf_clr → set wins.
- Reset asserted in any state immediately forces all reset values. Any in-flight sample is lost and no ack or event is produced for it.

## Timing
- req sampled high in IDLE at edge k → ack high during cycle k..k+1, EVAL at k+2, evt_valid high from edge k+3 (FIFO previously empty).
- Maximum throughput is one sample per 3 cycles. The next arbitration happens at edge k+3.
- Event latency from request to evt_valid is 3 cycles. Pop takes effect at the clock edge; evt_valid drops one cycle after the last pop.
- ovf rises at the edge ending the EVAL cycle that dropped the event.

## Configuration
- DEADBAND_SCAN_FIXED_PRIO_EN defined: fixed priority, lowest index wins. The rr pointer is unused and held at 0.
- DEADBAND_SCAN_FIXED_PRIO_EN not defined: round-robin arbitration as described in Operation.

## Test plan
- Reset, then req[0]=1 with sample0=0x05 and thr=2 → ack[0] one cycle; event {0, 0x05, 0x05} valid 3 cycles after request.
- Channel 0 then sends 0x07 → delta 2, no event, stored stays 0x05. Then 0x08 → event {0, 0x03, 0x08}. Stored 0xF0 with sample 0x10 → delta 0xE0.
- req=4'b1111 held with distinct samples → ack order 0,1,2,3,0. With DEADBAND_SCAN_FIXED_PRIO_EN, only ack[0] is ever asserted.
- evt_ready=0 and 5 qualifying events with DEPTH=4 → 4 queued, ovf=1, 5th dropped but its stored value updated. Draining returns events in order. ovf_clr then clears ovf.
- thr_we with 0x10, then delta 0x10 → no event; delta 0x11 → event. thr_we in the same cycle as EVAL → old threshold applied.
- rst_n asserted during EVAL with a qualifying sample → all outputs 0 immediately, FIFO empty, no event after reset release.
